// File: rtl/pc_sequencer.sv
// pc_sequencer: control sequencer for the 6502 program counter datapath.
// It turns single commands (INC, BRANCH, JUMP, VECTOR) into per-cycle
// hold/load/increment strobes for the PCL and PCH register blocks.
// It also handles PCH page fix-up after a branch and two-byte vector
// fetches from memory.
//
// Optional feature macro: PC_SEQ_VECTOR_EN
//   defined   : VECTOR command performs the two-byte vector read and load
//   undefined : VECTOR spends one hold-only cycle and then reports done
//
// Ports:
//   i_clk, i_reset            clock, asynchronous active-high reset
//   i_cmd_valid / o_ready     command handshake (accept when both are high)
//   i_cmd                     0=INC 1=BRANCH 2=JUMP 3=VECTOR
//   i_offset, i_target        branch displacement, jump destination
//   i_vec_sel                 0=NMI 1=RESET 2/3=IRQ
//   i_pcl, i_pch, i_pclc      current PC bytes, PCL increment carry out
//   o_pcl_pcl, o_adl_pcl      PCL select: hold / load from ADL
//   o_pch_pch, o_adh_pch      PCH select: hold / load from ADH
//   o_i_pc, o_i_pch           PCL / PCH increment
//   o_adl, o_adh              bus values for loads
//   o_mem_addr, o_mem_rd      vector read request (data returns next cycle)
//   i_mem_data                read data
//   o_done                    one-cycle pulse, new PC visible this cycle
module pc_sequencer (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_cmd_valid,
    output logic        o_ready,
    input  logic [1:0]  i_cmd,
    input  logic [7:0]  i_offset,
    input  logic [15:0] i_target,
    input  logic [1:0]  i_vec_sel,
    input  logic [7:0]  i_pcl,
    input  logic [7:0]  i_pch,
    input  logic        i_pclc,
    output logic        o_pcl_pcl,
    output logic        o_adl_pcl,
    output logic        o_pch_pch,
    output logic        o_adh_pch,
    output logic        o_i_pc,
    output logic        o_i_pch,
    output logic [7:0]  o_adl,
    output logic [7:0]  o_adh,
    output logic [15:0] o_mem_addr,
    output logic        o_mem_rd,
    input  logic [7:0]  i_mem_data,
    output logic        o_done
);

    typedef enum logic [2:0] {
        IDLE, INC, BR_LO, BR_FIX, JMP,
`ifdef PC_SEQ_VECTOR_EN
        VEC_RD_LO, VEC_RD_HI, VEC_LOAD
`else
        VEC_HOLD
`endif
    } state_t;

    state_t      state, state_nx;
    logic [7:0]  off_q, pcl_q, pch_q;
    logic [15:0] tgt_q;
    logic [8:0]  sum9;
    logic        page_cross;

    // Page crossing: carry out without a negative offset, or no carry with
    // a negative offset (i.e. a borrow). Both reduce to carry XOR sign.
    assign sum9       = {1'b0, pcl_q} + {1'b0, off_q};
    assign page_cross = sum9[8] ^ off_q[7];
    assign o_ready    = (state == IDLE);

`ifdef PC_SEQ_VECTOR_EN
    logic [1:0]  vec_q;
    logic [7:0]  lo_q;
    logic [15:0] vec_base;

    always_comb begin
        case (vec_q)
            2'd0:    vec_base = 16'hFFFA;
            2'd1:    vec_base = 16'hFFFC;
            default: vec_base = 16'hFFFE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            vec_q <= '0;
            lo_q  <= '0;
        end else begin
            if (o_ready && i_cmd_valid) vec_q <= i_vec_sel;
            // Low byte from the VEC_RD_LO read arrives during VEC_RD_HI.
            if (state == VEC_RD_HI)     lo_q  <= i_mem_data;
        end
    end
`else
    logic [9:0] unused_vec;
    assign unused_vec = {i_mem_data, i_vec_sel};
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state  <= IDLE;
            off_q  <= '0;
            pcl_q  <= '0;
            pch_q  <= '0;
            tgt_q  <= '0;
            o_done <= 1'b0;
        end else begin
            state  <= state_nx;
            o_done <= (state != IDLE) && (state_nx == IDLE);
            if (o_ready && i_cmd_valid) begin
                off_q <= i_offset;
                pcl_q <= i_pcl;
                pch_q <= i_pch;
                tgt_q <= i_target;
            end
        end
    end

    always_comb begin
        state_nx   = state;
        o_pcl_pcl  = 1'b0;
        o_adl_pcl  = 1'b0;
        o_pch_pch  = 1'b0;
        o_adh_pch  = 1'b0;
        o_i_pc     = 1'b0;
        o_i_pch    = 1'b0;
        o_adl      = '0;
        o_adh      = '0;
        o_mem_addr = '0;
        o_mem_rd   = 1'b0;
        case (state)
            IDLE: begin
                o_pcl_pcl = 1'b1;
                o_pch_pch = 1'b1;
                if (i_cmd_valid) begin
                    case (i_cmd)
                        2'd0:    state_nx = INC;
                        2'd1:    state_nx = BR_LO;
                        2'd2:    state_nx = JMP;
`ifdef PC_SEQ_VECTOR_EN
                        default: state_nx = VEC_RD_LO;
`else
                        default: state_nx = VEC_HOLD;
`endif
                    endcase
                end
            end
            INC: begin
                o_pcl_pcl = 1'b1;
                o_i_pc    = 1'b1;
                o_pch_pch = 1'b1;
                o_i_pch   = i_pclc;
                state_nx  = IDLE;
            end
            BR_LO: begin
                o_adl     = sum9[7:0];
                o_adl_pcl = 1'b1;
                o_pch_pch = 1'b1;
                state_nx  = page_cross ? BR_FIX : IDLE;
            end
            BR_FIX: begin
                o_adh     = off_q[7] ? pch_q - 8'd1 : pch_q + 8'd1;
                o_adh_pch = 1'b1;
                o_pcl_pcl = 1'b1;
                state_nx  = IDLE;
            end
            JMP: begin
                o_adl     = tgt_q[7:0];
                o_adh     = tgt_q[15:8];
                o_adl_pcl = 1'b1;
                o_adh_pch = 1'b1;
                state_nx  = IDLE;
            end
`ifdef PC_SEQ_VECTOR_EN
            VEC_RD_LO: begin
                o_pcl_pcl  = 1'b1;
                o_pch_pch  = 1'b1;
                o_mem_addr = vec_base;
                o_mem_rd   = 1'b1;
                state_nx   = VEC_RD_HI;
            end
            VEC_RD_HI: begin
                o_pcl_pcl  = 1'b1;
                o_pch_pch  = 1'b1;
                o_mem_addr = vec_base + 16'd1;
                o_mem_rd   = 1'b1;
                state_nx   = VEC_LOAD;
            end
            VEC_LOAD: begin
                o_adl     = lo_q;
                o_adh     = i_mem_data;
                o_adl_pcl = 1'b1;
                o_adh_pch = 1'b1;
                state_nx  = IDLE;
            end
`else
            VEC_HOLD: begin
                o_pcl_pcl = 1'b1;
                o_pch_pch = 1'b1;
                state_nx  = IDLE;
            end
`endif
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_cmd_valid = 1'b0;
    logic        o_ready;
    logic [1:0]  i_cmd = '0;
    logic [7:0]  i_offset = '0;
    logic [15:0] i_target = '0;
    logic [1:0]  i_vec_sel = '0;
    logic [7:0]  pcl = '0, pch = '0;
    logic        pclc;
    logic        o_pcl_pcl, o_adl_pcl, o_pch_pch, o_adh_pch, o_i_pc, o_i_pch;
    logic [7:0]  o_adl, o_adh;
    logic [15:0] o_mem_addr;
    logic        o_mem_rd;
    logic [7:0]  mem_data = '0;
    logic        o_done;

    logic [7:0]  mem [0:65535];
    int total = 0;
    int bad = 0;

    // Per-cycle captures of the last command (index 1 = first cycle after accept)
    logic [7:0]  cap_adl [0:15];
    logic [7:0]  cap_adh [0:15];
    logic [15:0] cap_addr[0:15];
    logic        cap_rd  [0:15];
    logic        cap_ipc [0:15];
    logic        cap_ipch[0:15];

`ifdef PC_SEQ_VECTOR_EN
    localparam bit VEC_EN = 1'b1;
`else
    localparam bit VEC_EN = 1'b0;
`endif

    pc_sequencer dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_cmd_valid(i_cmd_valid), .o_ready(o_ready),
        .i_cmd(i_cmd), .i_offset(i_offset), .i_target(i_target), .i_vec_sel(i_vec_sel),
        .i_pcl(pcl), .i_pch(pch), .i_pclc(pclc),
        .o_pcl_pcl(o_pcl_pcl), .o_adl_pcl(o_adl_pcl), .o_pch_pch(o_pch_pch),
        .o_adh_pch(o_adh_pch), .o_i_pc(o_i_pc), .o_i_pch(o_i_pch),
        .o_adl(o_adl), .o_adh(o_adh), .o_mem_addr(o_mem_addr), .o_mem_rd(o_mem_rd),
        .i_mem_data(mem_data), .o_done(o_done)
    );

    always #5 i_clk = ~i_clk;

    // Simple PC register blocks and a one-cycle-latency memory.
    assign pclc = (pcl == 8'hFF);
    always @(posedge i_clk) begin
        if (o_adl_pcl)   pcl <= o_adl;
        else if (o_i_pc) pcl <= pcl + 8'd1;
        if (o_adh_pch)    pch <= o_adh;
        else if (o_i_pch) pch <= pch + 8'd1;
        if (o_mem_rd) mem_data <= mem[o_mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] vec_addr(input logic [1:0] vs);
        return (vs == 2'd0) ? 16'hFFFA : (vs == 2'd1) ? 16'hFFFC : 16'hFFFE;
    endfunction

    // Reference: resulting PC and cycles from accept to o_done.
    task automatic run_cmd(input logic [1:0] c, input logic [7:0] off,
                           input logic [15:0] tgt, input logic [1:0] vs);
        logic [15:0] pc0, exp_pc, va;
        int exp_lat, n;
        pc0 = {pch, pcl};
        va  = vec_addr(vs);
        case (c)
            2'd0: begin exp_pc = pc0 + 16'd1; exp_lat = 2; end
            2'd1: begin
                exp_pc  = pc0 + {{8{off[7]}}, off};
                exp_lat = (exp_pc[15:8] != pc0[15:8]) ? 3 : 2;
            end
            2'd2: begin exp_pc = tgt; exp_lat = 2; end
            default: begin
                exp_pc  = VEC_EN ? {mem[va + 16'd1], mem[va]} : pc0;
                exp_lat = VEC_EN ? 4 : 2;
            end
        endcase
        check("ready_before_cmd", {31'd0, o_ready}, 32'd1);
        i_cmd = c; i_offset = off; i_target = tgt; i_vec_sel = vs; i_cmd_valid = 1'b1;
        @(posedge i_clk); #1;
        n = 1;
        while (!o_done && n < 12) begin
            check("ready_busy", {31'd0, o_ready}, 32'd0);
            cap_adl[n] = o_adl; cap_adh[n] = o_adh; cap_addr[n] = o_mem_addr;
            cap_rd[n] = o_mem_rd; cap_ipc[n] = o_i_pc; cap_ipch[n] = o_i_pch;
            // Garbage on the command inputs while busy must be ignored.
            i_cmd_valid = 1'($urandom); i_cmd = 2'($urandom);
            i_offset = 8'($urandom); i_target = 16'($urandom); i_vec_sel = 2'($urandom);
            @(posedge i_clk); #1;
            n++;
        end
        i_cmd_valid = 1'b0;
        check("done_seen", {31'd0, o_done}, 32'd1);
        check("latency", n, exp_lat);
        check("pc_result", {16'd0, pch, pcl}, {16'd0, exp_pc});
    endtask

    initial begin
        logic [15:0] pc_keep;
        logic [1:0]  rc;
        for (int a = 16'hFFFA; a <= 16'hFFFF; a++) mem[a] = 8'($urandom);

        // Reset state
        repeat (3) @(posedge i_clk);
        #1;
        check("rst_ready", {31'd0, o_ready}, 32'd1);
        check("rst_done", {31'd0, o_done}, 32'd0);
        check("rst_hold", {26'd0, o_pcl_pcl, o_adl_pcl, o_pch_pch, o_adh_pch, o_i_pc, o_i_pch}, 32'b101000);
        check("rst_bus", {o_adl, o_adh, o_mem_addr}, 32'd0);
        check("rst_rd", {31'd0, o_mem_rd}, 32'd0);
        i_reset = 1'b0;
        @(posedge i_clk); #1;

        // INC across a page
        run_cmd(2'd2, 8'h00, 16'h12FF, 2'd0);
        run_cmd(2'd0, 8'h00, 16'h0000, 2'd0);
        check("inc_ipc", {31'd0, cap_ipc[1]}, 32'd1);
        check("inc_ipch", {31'd0, cap_ipch[1]}, 32'd1);

        // Branch forward across a page
        run_cmd(2'd2, 8'h00, 16'h20F0, 2'd0);
        run_cmd(2'd1, 8'h20, 16'h0000, 2'd0);
        check("br_up_adl", {24'd0, cap_adl[1]}, 32'h10);
        check("br_up_adh", {24'd0, cap_adh[2]}, 32'h21);

        // Branch backward across page 0, then short branches
        run_cmd(2'd2, 8'h00, 16'h0005, 2'd0);
        run_cmd(2'd1, 8'hF0, 16'h0000, 2'd0);
        check("br_dn_adl", {24'd0, cap_adl[1]}, 32'hF5);
        check("br_dn_adh", {24'd0, cap_adh[2]}, 32'hFF);
        run_cmd(2'd2, 8'h00, 16'h0005, 2'd0);
        run_cmd(2'd1, 8'h02, 16'h0000, 2'd0);
        run_cmd(2'd1, 8'h00, 16'h0000, 2'd0);
        check("br_zero_adl", {24'd0, cap_adl[1]}, 32'h07);

        // JUMP then back-to-back INC
        run_cmd(2'd2, 8'h00, 16'hC000, 2'd0);
        run_cmd(2'd0, 8'h00, 16'h0000, 2'd0);

        // RESET vector
        mem[16'hFFFC] = 8'h34; mem[16'hFFFD] = 8'h12;
        run_cmd(2'd3, 8'h00, 16'h0000, 2'd1);
        if (VEC_EN) begin
            check("vec_rd1", {15'd0, cap_rd[1], cap_addr[1]}, {15'd0, 1'b1, 16'hFFFC});
            check("vec_rd2", {15'd0, cap_rd[2], cap_addr[2]}, {15'd0, 1'b1, 16'hFFFD});
        end

        // Reset in the middle of a vector fetch
        pc_keep = {pch, pcl};
        i_cmd = 2'd3; i_vec_sel = 2'd2; i_cmd_valid = 1'b1;
        @(posedge i_clk); #1;
        i_cmd_valid = 1'b0;
        if (VEC_EN) begin
            @(posedge i_clk); #1;
        end
        i_reset = 1'b1;
        #1;
        check("mid_rst_ready", {31'd0, o_ready}, 32'd1);
        check("mid_rst_done", {31'd0, o_done}, 32'd0);
        check("mid_rst_rd", {31'd0, o_mem_rd}, 32'd0);
        @(posedge i_clk); #1;
        i_reset = 1'b0;
        @(posedge i_clk); #1;
        check("mid_rst_done2", {31'd0, o_done}, 32'd0);
        check("mid_rst_pc", {16'd0, pch, pcl}, {16'd0, pc_keep});

        // Random command stream
        for (int i = 0; i < 80; i++) begin
            rc = 2'($urandom);
            if (rc == 2'd3)
                for (int a = 16'hFFFA; a <= 16'hFFFF; a++) mem[a] = 8'($urandom);
            run_cmd(rc, 8'($urandom), 16'($urandom), 2'($urandom));
            repeat ($urandom_range(0, 2)) begin
                @(posedge i_clk); #1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
